// File: rtl/mux_scan_sequencer.sv
// Sequencer for a 4:1 single-bit mux: steps sel over the enabled channels, waits
// SETTLE_CYC cycles per channel and captures y. Optional SCAN_SWEEP_DONE_EN adds sweep_done.
module mux_scan_sequencer #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       cont,
  input  logic [3:0] ch_mask,
  input  logic       y,
  output logic [1:0] sel,
  output logic       busy,
  output logic       sample_stb,
  output logic       sample_bit,
  output logic [1:0] sample_ch,
  output logic       err_mask
`ifdef SCAN_SWEEP_DONE_EN
  ,
  output logic       sweep_done
`endif
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q;
  logic [3:0]       mask_q;
  logic             cont_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sel_q;
  logic             busy_q;
  logic             stb_q;
  logic             bit_q;
  logic [1:0]       ch_q;
  logic             err_q;
`ifdef SCAN_SWEEP_DONE_EN
  logic             done_q;
`endif

  logic [1:0]       next_sel_d;
  logic             last_ch_d;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Descending search so the last hit is the nearest enabled channel above sel;
  // no hit means sel is the highest enabled channel and the scan wraps.
  always_comb begin
    next_sel_d = lowest_ch(mask_q);
    last_ch_d  = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(sel_q))) begin
        next_sel_d = 2'(i);
        last_ch_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= 4'd0;
      cont_q  <= 1'b0;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      bit_q   <= 1'b0;
      ch_q    <= 2'd0;
      err_q   <= 1'b0;
`ifdef SCAN_SWEEP_DONE_EN
      done_q  <= 1'b0;
`endif
    end else begin
      stb_q  <= 1'b0;
      err_q  <= 1'b0;
`ifdef SCAN_SWEEP_DONE_EN
      done_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            if (ch_mask != 4'd0) begin
              mask_q  <= ch_mask;
              cont_q  <= cont;
              sel_q   <= lowest_ch(ch_mask);
              cnt_q   <= SETTLE_LD;
              busy_q  <= 1'b1;
              state_q <= SCAN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_ONE) begin
            bit_q  <= y;
            ch_q   <= sel_q;
            stb_q  <= 1'b1;
            cnt_q  <= SETTLE_LD;
`ifdef SCAN_SWEEP_DONE_EN
            done_q <= last_ch_d;
`endif
            // End of a single sweep leaves sel on the last channel sampled.
            if (last_ch_d && !cont_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              sel_q <= next_sel_d;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // busy is the registered view of the FSM state (1 = SCAN).
  assign sel        = sel_q;
  assign busy       = busy_q;
  assign sample_stb = stb_q;
  assign sample_bit = bit_q;
  assign sample_ch  = ch_q;
  assign err_mask   = err_q;
`ifdef SCAN_SWEEP_DONE_EN
  assign sweep_done = done_q;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: one instance with SETTLE_CYC=2, one with SETTLE_CYC=1.
// Cycle n is the interval after clock edge n; outputs are sampled 1 time unit after the edge.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, stop, cont, y;
  logic [3:0] ch_mask;
  logic [1:0] sel, sample_ch;
  logic       busy, sample_stb, sample_bit, err_mask;

  logic       start1, stop1, cont1, y1;
  logic [3:0] mask1;
  logic [1:0] sel1, sample_ch1;
  logic       busy1, sample_stb1, sample_bit1, err_mask1;
`ifdef SCAN_SWEEP_DONE_EN
  logic       sweep_done, sweep_done1;
`endif

  assign y  = sel[0];
  assign y1 = sel1[1];

  mux_scan_sequencer #(.SETTLE_CYC(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
    .ch_mask(ch_mask), .y(y), .sel(sel), .busy(busy), .sample_stb(sample_stb),
    .sample_bit(sample_bit), .sample_ch(sample_ch), .err_mask(err_mask)
`ifdef SCAN_SWEEP_DONE_EN
    , .sweep_done(sweep_done)
`endif
  );

  mux_scan_sequencer #(.SETTLE_CYC(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1), .cont(cont1),
    .ch_mask(mask1), .y(y1), .sel(sel1), .busy(busy1), .sample_stb(sample_stb1),
    .sample_bit(sample_bit1), .sample_ch(sample_ch1), .err_mask(err_mask1)
`ifdef SCAN_SWEEP_DONE_EN
    , .sweep_done(sweep_done1)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_dut(input string tag, input int c, input logic [1:0] e_sel,
                            input logic e_busy, input logic e_stb, input logic [1:0] e_ch,
                            input logic e_bit, input logic e_done);
    check($sformatf("%s c%0d sel", tag, c), 8'(sel), 8'(e_sel));
    check($sformatf("%s c%0d busy", tag, c), 8'(busy), 8'(e_busy));
    check($sformatf("%s c%0d stb", tag, c), 8'(sample_stb), 8'(e_stb));
    if (e_stb) begin
      check($sformatf("%s c%0d ch", tag, c), 8'(sample_ch), 8'(e_ch));
      check($sformatf("%s c%0d bit", tag, c), 8'(sample_bit), 8'(e_bit));
    end
`ifdef SCAN_SWEEP_DONE_EN
    check($sformatf("%s c%0d done", tag, c), 8'(sweep_done), 8'(e_done));
`else
    if (e_done) begin end
`endif
  endtask

  // Single sweep over mask 1111 with SETTLE_CYC=2: sel 0,1,2,3 from cycles 1,3,5,7,
  // strobes at 3,5,7,9, busy falls at 9. Optionally disturb inputs mid-scan.
  task automatic run_sweep(input string tag, input bit disturb);
    int ch;
    logic s;
    ch_mask = 4'b1111; cont = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      s  = (c >= 3) && (c % 2 == 1);
      ch = (c - 3) / 2;
      expect_dut(tag, c, (c >= 7) ? 2'd3 : 2'((c - 1) / 2), c < 9, s,
                 2'(ch), ch[0], s && (ch == 3));
      if (disturb && c == 4) begin
        ch_mask = 4'b0001; cont = 1'b1; start = 1'b1;
      end
      if (disturb && c == 5) start = 1'b0;
      tick();
    end
    expect_dut(tag, 10, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int  ch;
    logic s;
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; ch_mask = 4'd0;
    start1 = 1'b0; stop1 = 1'b0; cont1 = 1'b0; mask1 = 4'd0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    expect_dut("reset", 0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    check("reset ch", 8'(sample_ch), 8'd0);
    check("reset bit", 8'(sample_bit), 8'd0);
    check("reset err", 8'(err_mask), 8'd0);
    check("reset busy1", 8'(busy1), 8'd0);

    run_sweep("sweep", 1'b0);
    run_sweep("disturb", 1'b1);
    ch_mask = 4'b1111;

    // Continuous mask 1010: sel alternates 1/3, strobes ch 1,3,1,3; stop in a counter==1 cycle.
    ch_mask = 4'b1010; cont = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      s  = (c >= 3) && (c % 2 == 1);
      ch = (((c - 3) / 2) % 2 == 1) ? 3 : 1;
      expect_dut("cont", c, (((c - 1) / 2) % 2 == 1) ? 2'd3 : 2'd1, 1'b1, s,
                 2'(ch), 1'b1, s && (ch == 3));
      if (c == 12) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    expect_dut("stop", 13, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    expect_dut("stop", 14, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    // Empty mask: err_mask pulses once, nothing else moves.
    ch_mask = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("errmask pulse", 8'(err_mask), 8'd1);
    expect_dut("errmask", 1, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    check("errmask clear", 8'(err_mask), 8'd0);

    // start and stop together with an empty mask: stop wins, no error pulse.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("startstop err", 8'(err_mask), 8'd0);
    check("startstop busy", 8'(busy), 8'd0);

    // Reset mid-scan at a counter==1 cycle (c6, sel=2, last strobe ch1 bit1).
    ch_mask = 4'b1111; cont = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) begin
        check("prerst ch", 8'(sample_ch), 8'd1);
        check("prerst sel", 8'(sel), 8'd2);
        rst = 1'b1;
      end
      tick();
    end
    rst = 1'b0;
    expect_dut("midrst", 7, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    check("midrst ch", 8'(sample_ch), 8'd0);
    check("midrst bit", 8'(sample_bit), 8'd0);
    tick();
    check("midrst stb", 8'(sample_stb), 8'd0);

    // SETTLE_CYC=1, mask 0100, continuous: strobe every cycle on ch2.
    mask1 = 4'b0100; cont1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("s1 c1 sel", 8'(sel1), 8'd2);
    check("s1 c1 busy", 8'(busy1), 8'd1);
    check("s1 c1 stb", 8'(sample_stb1), 8'd0);
    tick();
    for (int c = 2; c <= 6; c++) begin
      check($sformatf("s1 c%0d stb", c), 8'(sample_stb1), 8'd1);
      check($sformatf("s1 c%0d ch", c), 8'(sample_ch1), 8'd2);
      check($sformatf("s1 c%0d bit", c), 8'(sample_bit1), 8'd1);
`ifdef SCAN_SWEEP_DONE_EN
      check($sformatf("s1 c%0d done", c), 8'(sweep_done1), 8'd1);
`endif
      if (c == 6) stop1 = 1'b1;
      tick();
    end
    stop1 = 1'b0;
    check("s1 stop busy", 8'(busy1), 8'd0);
    check("s1 stop stb", 8'(sample_stb1), 8'd0);
    check("s1 stop sel", 8'(sel1), 8'd2);

    // start and stop together in IDLE with a valid mask: no scan.
    start1 = 1'b1; stop1 = 1'b1;
    tick();
    start1 = 1'b0; stop1 = 1'b0;
    check("s1 ss busy", 8'(busy1), 8'd0);
    check("s1 ss err", 8'(err_mask1), 8'd0);
    tick();
    check("s1 ss busy2", 8'(busy1), 8'd0);
    check("s1 ss stb2", 8'(sample_stb1), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
